// File: rtl/dac_spi_rx.sv
// rtl/dac_spi_rx.sv - oversampling SPI receive endpoint for the DAC threshold link
module dac_spi_rx #(
  parameter int DATA_WIDTH  = 24,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  sync_i,
  input  logic                  sclk_i,
  input  logic                  sdi_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  err_o,
  output logic                  ovf_o,
  output logic                  busy_o,
  output logic [CNT_WIDTH-1:0]  frame_cnt_o
);

  // Bit counter must hold DATA_WIDTH+1 so overruns stay distinguishable.
  localparam int BCW = $clog2(DATA_WIDTH + 2);
  localparam logic [BCW-1:0] BIT_GOOD = BCW'(DATA_WIDTH);
  localparam logic [BCW-1:0] BIT_MAX  = BCW'(DATA_WIDTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sync_ff, sclk_ff, sdi_ff;
  logic                   sync_d, sclk_d, sdi_d;
  logic                   sync_s, sclk_s;
  logic                   sync_fall, sync_rise, sclk_fall;

  logic [DATA_WIDTH-1:0]  shift_q;
  logic [BCW-1:0]         bit_cnt;

  logic clr_frame, do_shift, frame_end;
  logic good_frame, bad_frame, load_out;

  // Synchronizer chains plus one delay flop per line; idle levels on reset.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      sync_ff <= '1;
      sclk_ff <= '1;
      sdi_ff  <= '0;
      sync_d  <= 1'b1;
      sclk_d  <= 1'b1;
      sdi_d   <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], sync_i};
      sclk_ff <= {sclk_ff[SYNC_STAGES-2:0], sclk_i};
      sdi_ff  <= {sdi_ff[SYNC_STAGES-2:0], sdi_i};
      sync_d  <= sync_ff[SYNC_STAGES-1];
      sclk_d  <= sclk_ff[SYNC_STAGES-1];
      sdi_d   <= sdi_ff[SYNC_STAGES-1];
    end
  end

  assign sync_s    = sync_ff[SYNC_STAGES-1];
  assign sclk_s    = sclk_ff[SYNC_STAGES-1];
  assign sync_fall = !sync_s && sync_d;
  assign sync_rise = sync_s && !sync_d;
  // SCLK falls only matter inside a frame.
  assign sclk_fall = !sclk_s && sclk_d && !sync_s;

  // FSM state register.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state and per-cycle frame controls; a SCLK fall coinciding with the
  // SYNC fall is swallowed because IDLE never shifts.
  always_comb begin
    state_nxt = state;
    clr_frame = 1'b0;
    do_shift  = 1'b0;
    frame_end = 1'b0;
    case (state)
      IDLE: begin
        if (sync_fall) begin
          clr_frame = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (sync_rise) begin
          frame_end = 1'b1;
          state_nxt = IDLE;
        end else if (sclk_fall) begin
          do_shift = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign good_frame = frame_end && (bit_cnt == BIT_GOOD);
  assign bad_frame  = frame_end && (bit_cnt != BIT_GOOD);
  assign load_out   = good_frame && (!valid_o || ready_i);

  // Shift register and saturating bit counter.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else if (clr_frame) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else if (do_shift) begin
      shift_q <= {shift_q[DATA_WIDTH-2:0], sdi_d};
      if (bit_cnt != BIT_MAX) bit_cnt <= bit_cnt + BCW'(1);
    end
  end

  // Output register, handshake, status pulses and good-frame counter.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      data_o      <= '0;
      valid_o     <= 1'b0;
      err_o       <= 1'b0;
      ovf_o       <= 1'b0;
      busy_o      <= 1'b0;
      frame_cnt_o <= '0;
    end else begin
      err_o  <= bad_frame;
      ovf_o  <= good_frame && !load_out;
      busy_o <= !sync_s;
      if (good_frame) frame_cnt_o <= frame_cnt_o + CNT_WIDTH'(1);
      if (load_out) begin
        data_o  <= shift_q;
        valid_o <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dac_spi_rx.sv
// tb/tb_dac_spi_rx.sv - scoreboard bench for dac_spi_rx
module tb_dac_spi_rx;

  localparam int DW = 24;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          arstn = 1'b0;
  logic          sync = 1'b1;
  logic          sclk = 1'b1;
  logic          sdi = 1'b0;
  logic          ready = 1'b0;
  logic [DW-1:0] data;
  logic          valid, err, ovf, busy;
  logic [CW-1:0] cnt;

  dac_spi_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(2), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .arstn_i(arstn), .sync_i(sync), .sclk_i(sclk), .sdi_i(sdi),
    .data_o(data), .valid_o(valid), .ready_i(ready), .err_o(err), .ovf_o(ovf),
    .busy_o(busy), .frame_cnt_o(cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          err;
    logic          ovf;
    logic          valid;
    logic [DW-1:0] data;
    logic [CW-1:0] cnt;
  } ev_t;

  ev_t exp_q[$];
  int  n_vec  = 0;
  int  n_miss = 0;

  logic [DW-1:0] m_data  = '0;
  logic          m_valid = 1'b0;
  logic [CW-1:0] m_cnt   = '0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic expect_good(input logic [DW-1:0] w, input logic rdy_held);
    ev_t e;
    m_cnt = m_cnt + 1'b1;
    e.ovf = 1'b0;
    if (!m_valid || rdy_held) m_data = w;
    else e.ovf = 1'b1;
    e.err   = 1'b0;
    e.valid = 1'b1;
    e.data  = m_data;
    e.cnt   = m_cnt;
    exp_q.push_back(e);
    m_valid = rdy_held ? 1'b0 : 1'b1;
  endtask

  task automatic expect_err();
    ev_t e;
    e.err = 1'b1; e.ovf = 1'b0; e.valid = m_valid; e.data = m_data; e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic spi_bit(input logic b);
    sdi = b;
    tick(3);
    sclk = 1'b0;
    tick(3);
    sclk = 1'b1;
  endtask

  task automatic send_frame(input logic [31:0] w, input int nbits);
    sync = 1'b0;
    tick(3);
    for (int i = nbits - 1; i >= 0; i--) spi_bit(w[i]);
    tick(3);
    sync = 1'b1;
  endtask

  task automatic model_reset();
    m_data = '0; m_valid = 1'b0; m_cnt = '0;
  endtask

  // Monitor: any status pulse or counter change is an observable event.
  logic [CW-1:0] prev_cnt = '0;
  always @(negedge clk) begin
    ev_t o, e;
    if (arstn && (err || ovf || cnt != prev_cnt)) begin
      o.err = err; o.ovf = ovf; o.valid = valid; o.data = data; o.cnt = cnt;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_event: got err=%b ovf=%b valid=%b data=%h cnt=%0d, none expected",
                 err, ovf, valid, data, cnt);
      end else begin
        e = exp_q.pop_front();
        if (o !== e) begin
          n_miss++;
          $display("FAIL event: got err=%b ovf=%b valid=%b data=%h cnt=%0d want err=%b ovf=%b valid=%b data=%h cnt=%0d",
                   o.err, o.ovf, o.valid, o.data, o.cnt, e.err, e.ovf, e.valid, e.data, e.cnt);
        end
      end
    end
    prev_cnt <= cnt;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tick(3);
    check("rst_data", data, 0);
    check("rst_valid", valid, 0);
    check("rst_err_ovf_busy", {err, ovf, busy}, 0);
    check("rst_cnt", cnt, 0);
    arstn = 1'b1;
    tick(5);

    // Good frame with latency check
    expect_good(24'h00ABCD, 1'b0);
    send_frame(32'h00ABCD, 24);
    tick(2);
    check("t1_valid_before", valid, 0);
    tick(1);
    check("t1_valid_at3", valid, 1);
    check("t1_data", data, 32'h00ABCD);
    check("t1_cnt", cnt, 1);
    tick(5);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    m_valid = 1'b0;
    check("t1_consumed", valid, 0);
    tick(3);

    // Bad bit counts
    expect_err();
    send_frame(32'h0055AA, 23);
    tick(8);
    expect_err();
    send_frame(32'h1123456, 25);
    tick(8);
    check("t2_valid", valid, 0);
    check("t2_cnt", cnt, 1);

    // Overflow, then ready held
    expect_good(24'h111111, 1'b0);
    send_frame(32'h111111, 24);
    tick(8);
    expect_good(24'h222222, 1'b0);
    send_frame(32'h222222, 24);
    tick(8);
    check("t3_data_kept", data, 32'h111111);
    ready = 1'b1;
    m_valid = 1'b0;
    tick(3);
    expect_good(24'h111111, 1'b1);
    send_frame(32'h111111, 24);
    tick(8);
    expect_good(24'h222222, 1'b1);
    send_frame(32'h222222, 24);
    tick(8);
    check("t3_data_new", data, 32'h222222);
    ready = 1'b0;
    tick(3);

    // SCLK toggles outside a frame are ignored
    for (int i = 0; i < 10; i++) begin
      sdi = i[0];
      sclk = 1'b0; tick(3);
      sclk = 1'b1; tick(3);
    end
    check("t4_idle_busy", busy, 0);
    expect_good(24'hFFFFFF, 1'b0);
    send_frame(32'hFFFFFF, 24);
    tick(8);
    check("t4_data", data, 32'hFFFFFF);

    // Reset mid-frame
    sync = 1'b0;
    tick(3);
    for (int i = 0; i < 12; i++) spi_bit(1'b1);
    check("t5_busy_mid", busy, 1);
    arstn = 1'b0;
    sync = 1'b1;
    sclk = 1'b1;
    tick(2);
    model_reset();
    check("t5_rst_data", data, 0);
    check("t5_rst_valid", valid, 0);
    check("t5_rst_err_ovf_busy", {err, ovf, busy}, 0);
    check("t5_rst_cnt", cnt, 0);
    arstn = 1'b1;
    tick(5);
    expect_good(24'h800001, 1'b0);
    send_frame(32'h800001, 24);
    tick(8);
    check("t5_data", data, 32'h800001);
    check("t5_cnt", cnt, 1);

    // Counter wrap with 17 frames
    arstn = 1'b0;
    tick(2);
    model_reset();
    arstn = 1'b1;
    ready = 1'b1;
    tick(3);
    for (int i = 0; i < 17; i++) begin
      logic [DW-1:0] w;
      w = DW'(32'h010203 * (i + 1));
      expect_good(w, 1'b1);
      send_frame({8'h00, w}, 24);
      tick(8);
    end
    check("t6_cnt_end", cnt, 1);
    ready = 1'b0;

    tick(10);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
